// File: rtl/interrupt_controller_if.sv
// -----------------------------------------------------------------------------
// interrupt_controller_if
//
// Purpose: bundles the RAT MCU port bus and the interrupt handshake that run
//          between the control unit (master) and the interrupt controller
//          (slave).
//
// Signals:
//   PORT_ID   master->slave  8-bit port address
//   OUT_PORT  master->slave  8-bit write data
//   IO_STRB   master->slave  one-cycle write strobe for an OUT instruction
//   INT_ACK   master->slave  one-cycle pulse when the CU enters its interrupt state
//   IN_DATA   slave->master  8-bit combinational read data, 0 when unmapped
//   INTERUPT  slave->master  registered interrupt request
//
// Handshake: INTERUPT is a level request; the control unit answers with a
// single-cycle INT_ACK, which consumes exactly one pending source. The CU must
// not resample INTERUPT until it has returned from the ISR.
// -----------------------------------------------------------------------------
interface interrupt_controller_if;
   logic [7:0] PORT_ID;
   logic [7:0] OUT_PORT;
   logic       IO_STRB;
   logic       INT_ACK;
   logic [7:0] IN_DATA;
   logic       INTERUPT;

   modport master (
      output PORT_ID,
      output OUT_PORT,
      output IO_STRB,
      output INT_ACK,
      input  IN_DATA,
      input  INTERUPT
   );

   modport slave (
      input  PORT_ID,
      input  OUT_PORT,
      input  IO_STRB,
      input  INT_ACK,
      output IN_DATA,
      output INTERUPT
   );
endinterface

// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Purpose: multi-source interrupt controller for the RAT MCU. Each IRQ line is
//          synchronised, rising-edge detected and latched as a pending bit.
//          Pending bits gated by a software mask form one registered request.
//          On acknowledge the lowest-numbered masked pending source is
//          recorded in active_id and cleared.
//
// Ports:
//   CLK     in   system clock, rising edge
//   RESET   in   asynchronous active-high reset
//   IRQ_IN  in   NUM_SRC asynchronous request lines, rising-edge sensitive
//   bus     slave modport of interrupt_controller_if (port bus + INT_ACK /
//           INTERUPT handshake)
//
// Register map (port IDs):
//   MASK_ADDR  read/write      mask
//   PEND_ADDR  read, W1C       pending
//   ID_ADDR    read only       active_id (8'hFF = spurious / none)
// -----------------------------------------------------------------------------
module interrupt_controller #(
   parameter int         NUM_SRC     = 8,
   parameter int         SYNC_STAGES = 2,
   parameter logic [7:0] MASK_ADDR   = 8'h30,
   parameter logic [7:0] PEND_ADDR   = 8'h31,
   parameter logic [7:0] ID_ADDR     = 8'h32
) (
   input  logic                  CLK,
   input  logic                  RESET,
   input  logic [NUM_SRC-1:0]    IRQ_IN,
   interrupt_controller_if.slave bus
);

   // Synchroniser chain plus previous-value register. Reset to all ones so a
   // line already high when reset releases does not look like a new edge.
   logic [NUM_SRC-1:0] sync_q [SYNC_STAGES];
   logic [NUM_SRC-1:0] prev_q;

   logic [NUM_SRC-1:0] mask_q;
   logic [NUM_SRC-1:0] pending_q;
   logic [7:0]         active_id_q;
   logic               interupt_q;

   logic [NUM_SRC-1:0] irq_edge;
   logic [NUM_SRC-1:0] req;
   logic [NUM_SRC-1:0] ack_clr;
   logic [NUM_SRC-1:0] w1c_clr;
   logic [NUM_SRC-1:0] pending_next;
   logic [2:0]         sel;
   logic               sel_found;
   logic               mask_wr;
   logic               pend_wr;
   logic [7:0]         mask_rd;
   logic [7:0]         pend_rd;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         for (int s = 0; s < SYNC_STAGES; s++) begin
            sync_q[s] <= '1;
         end
         prev_q <= '1;
      end else begin
         sync_q[0] <= IRQ_IN;
         for (int s = 1; s < SYNC_STAGES; s++) begin
            sync_q[s] <= sync_q[s-1];
         end
         prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign irq_edge = sync_q[SYNC_STAGES-1] & ~prev_q;
   assign req      = pending_q & mask_q;
   assign mask_wr  = bus.IO_STRB && (bus.PORT_ID == MASK_ADDR);
   assign pend_wr  = bus.IO_STRB && (bus.PORT_ID == PEND_ADDR);

   // Fixed priority: scanning downward leaves the lowest requesting index.
   always_comb begin
      sel       = 3'd0;
      sel_found = 1'b0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (req[i]) begin
            sel       = 3'(i);
            sel_found = 1'b1;
         end
      end
   end

   always_comb begin
      ack_clr = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         ack_clr[i] = bus.INT_ACK && sel_found && (sel == 3'(i));
      end
   end

   assign w1c_clr = pend_wr ? bus.OUT_PORT[NUM_SRC-1:0] : '0;

   // A fresh edge always wins over any clear in the same cycle.
   assign pending_next = (pending_q & ~ack_clr & ~w1c_clr) | irq_edge;

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         mask_q      <= '0;
         pending_q   <= '0;
         active_id_q <= 8'hFF;
         interupt_q  <= 1'b0;
      end else begin
         pending_q  <= pending_next;
         interupt_q <= |req;
         if (mask_wr) begin
            mask_q <= bus.OUT_PORT[NUM_SRC-1:0];
         end
         if (bus.INT_ACK) begin
            active_id_q <= sel_found ? {5'b0, sel} : 8'hFF;
         end
      end
   end

   // Zero-extend to the 8-bit bus; unimplemented upper bits read as 0.
   always_comb begin
      mask_rd                = '0;
      mask_rd[NUM_SRC-1:0]   = mask_q;
      pend_rd                = '0;
      pend_rd[NUM_SRC-1:0]   = pending_q;
   end

   // Unmapped ports return 0 so this output can be OR-merged with other
   // peripherals on the IN bus.
   always_comb begin
      bus.IN_DATA = 8'h00;
      if (bus.PORT_ID == MASK_ADDR) begin
         bus.IN_DATA = mask_rd;
      end else if (bus.PORT_ID == PEND_ADDR) begin
         bus.IN_DATA = pend_rd;
      end else if (bus.PORT_ID == ID_ADDR) begin
         bus.IN_DATA = active_id_q;
      end
   end

   assign bus.INTERUPT = interupt_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Self-checking bench for interrupt_controller (default parameters).
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

   localparam int S = 2;

   logic       clk;
   logic       rst;
   logic [7:0] irq;

   interrupt_controller_if bus();

   interrupt_controller #(
      .NUM_SRC(8), .SYNC_STAGES(S),
      .MASK_ADDR(8'h30), .PEND_ADDR(8'h31), .ID_ADDR(8'h32)
   ) dut (
      .CLK(clk),
      .RESET(rst),
      .IRQ_IN(irq),
      .bus(bus)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // ---------------- behavioural model ----------------
   logic [7:0] m_mask, m_pend, m_id;
   logic       m_intr;
   logic [7:0] hist[$];   // hist[0] = IRQ value seen at the latest edge

   task automatic model_reset();
      m_mask = 8'h00;
      m_pend = 8'h00;
      m_id   = 8'hFF;
      m_intr = 1'b0;
      hist.delete();
      for (int k = 0; k < S + 2; k++) hist.push_back(8'hFF);
   endtask

   task automatic model_step(input logic [7:0] i_irq, input logic [7:0] i_port,
                             input logic [7:0] i_data, input logic i_strb,
                             input logic i_ack);
      logic [7:0] edges, clr, req;
      bit         found;
      hist.push_front(i_irq);
      // A rise seen S edges ago lands in pending now.
      edges = hist[S] & ~hist[S+1];
      void'(hist.pop_back());
      req   = m_pend & m_mask;
      clr   = 8'h00;
      if (i_ack) begin
         found = 0;
         for (int i = 0; i < 8; i++) begin
            if (!found && req[i]) begin
               found  = 1;
               m_id   = 8'(i);
               clr[i] = 1'b1;
            end
         end
         if (!found) m_id = 8'hFF;
      end
      if (i_strb && i_port == 8'h31) clr = clr | i_data;
      m_intr = (req != 0);
      m_pend = (m_pend & ~clr) | edges;
      if (i_strb && i_port == 8'h30) m_mask = i_data;
   endtask

   function automatic logic [7:0] model_read(input logic [7:0] p);
      case (p)
         8'h30:   return m_mask;
         8'h31:   return m_pend;
         8'h32:   return m_id;
         default: return 8'h00;
      endcase
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic [7:0] port, input logic [7:0] data,
                        input logic strb, input logic ack);
      bus.PORT_ID  = port;
      bus.OUT_PORT = data;
      bus.IO_STRB  = strb;
      bus.INT_ACK  = ack;
   endtask

   // One clock: model sees the same inputs the DUT sees at the edge; outputs
   // are then sampled 1 time unit later.
   task automatic tick();
      logic [7:0] c_irq, c_port, c_data;
      logic       c_strb, c_ack, c_rst;
      c_irq = irq; c_port = bus.PORT_ID; c_data = bus.OUT_PORT;
      c_strb = bus.IO_STRB; c_ack = bus.INT_ACK; c_rst = rst;
      @(posedge clk);
      if (c_rst) model_reset();
      else       model_step(c_irq, c_port, c_data, c_strb, c_ack);
      #1;
   endtask

   // ---------------- scoreboard helpers ----------------
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic read_chk(input string name, input logic [7:0] port, input logic [7:0] exp);
      bus.PORT_ID = port;
      bus.IO_STRB = 1'b0;
      bus.INT_ACK = 1'b0;
      #1;
      chk(name, bus.IN_DATA, exp);
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic [7:0] irq;
      logic [7:0] port;
      logic [7:0] data;
      logic       strb;
      logic       ack;
      logic       exp_intr;
      logic [7:0] exp_rd;
   } vec_t;

   vec_t vecs[11];

   initial begin
      // single source, spurious ack, unmapped and read-only writes
      vecs[0]  = '{8'h00, 8'h30, 8'h01, 1'b1, 1'b0, 1'b0, 8'h01}; // mask=01
      vecs[1]  = '{8'h01, 8'h31, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}; // irq0 rises (edge k)
      vecs[2]  = '{8'h00, 8'h31, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
      vecs[3]  = '{8'h00, 8'h31, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01}; // pending at k+2
      vecs[4]  = '{8'h00, 8'h31, 8'h00, 1'b0, 1'b0, 1'b1, 8'h01}; // INTERUPT at k+3
      vecs[5]  = '{8'h00, 8'h32, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00}; // ack -> id 0
      vecs[6]  = '{8'h00, 8'h31, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00}; // request drops
      vecs[7]  = '{8'h00, 8'h32, 8'h00, 1'b0, 1'b1, 1'b0, 8'hFF}; // spurious ack
      vecs[8]  = '{8'h00, 8'h40, 8'hFF, 1'b1, 1'b0, 1'b0, 8'h00}; // unmapped port
      vecs[9]  = '{8'h00, 8'h32, 8'h05, 1'b1, 1'b0, 1'b0, 8'hFF}; // ID write ignored
      vecs[10] = '{8'h00, 8'h30, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01}; // mask unchanged
   end

   // ---------------- main test ----------------
   initial begin
      rst = 1'b1;
      irq = 8'h00;
      drive(8'h00, 8'h00, 1'b0, 1'b0);
      model_reset();
      tick();
      tick();
      rst = 1'b0;

      // reset state
      read_chk("reset_intr", {7'b0, bus.INTERUPT}, 8'h00);
      read_chk("reset_mask", 8'h30, 8'h00);
      read_chk("reset_pend", 8'h31, 8'h00);
      read_chk("reset_id",   8'h32, 8'hFF);

      // table
      for (int v = 0; v < 11; v++) begin
         irq = vecs[v].irq;
         drive(vecs[v].port, vecs[v].data, vecs[v].strb, vecs[v].ack);
         tick();
         chk($sformatf("vec%0d_intr", v), {7'b0, bus.INTERUPT}, {7'b0, vecs[v].exp_intr});
         chk($sformatf("vec%0d_rd", v), bus.IN_DATA, vecs[v].exp_rd);
      end
      drive(8'h00, 8'h00, 1'b0, 1'b0);

      // priority: sources 5 and 2 together
      drive(8'h30, 8'hFF, 1'b1, 1'b0); tick(); drive(8'h00, 8'h00, 1'b0, 1'b0);
      irq = 8'h24; tick(); irq = 8'h00; tick(); tick(); tick();
      chk("prio_intr", {7'b0, bus.INTERUPT}, 8'h01);
      read_chk("prio_pend", 8'h31, 8'h24);
      drive(8'h32, 8'h00, 1'b0, 1'b1); tick(); drive(8'h32, 8'h00, 1'b0, 1'b0);
      read_chk("prio_id1", 8'h32, 8'h02);
      read_chk("prio_pend1", 8'h31, 8'h20);
      drive(8'h32, 8'h00, 1'b0, 1'b1); tick(); drive(8'h32, 8'h00, 1'b0, 1'b0);
      read_chk("prio_id2", 8'h32, 8'h05);
      tick();
      chk("prio_intr_fall", {7'b0, bus.INTERUPT}, 8'h00);

      // masking
      drive(8'h30, 8'h00, 1'b1, 1'b0); tick(); drive(8'h00, 8'h00, 1'b0, 1'b0);
      irq = 8'h08; tick(); irq = 8'h00; tick(); tick(); tick();
      read_chk("mask_pend", 8'h31, 8'h08);
      chk("mask_intr_low", {7'b0, bus.INTERUPT}, 8'h00);
      drive(8'h30, 8'h08, 1'b1, 1'b0); tick(); drive(8'h00, 8'h00, 1'b0, 1'b0);
      chk("mask_intr_wait", {7'b0, bus.INTERUPT}, 8'h00);
      tick();
      chk("unmask_intr", {7'b0, bus.INTERUPT}, 8'h01);
      drive(8'h31, 8'h08, 1'b1, 1'b0); tick(); drive(8'h00, 8'h00, 1'b0, 1'b0);
      read_chk("w1c_pend", 8'h31, 8'h00);

      // clear/edge collision on source 4
      irq = 8'h10; tick(); irq = 8'h00; tick();
      drive(8'h31, 8'h10, 1'b1, 1'b0); tick(); drive(8'h31, 8'h00, 1'b0, 1'b0);
      read_chk("collide_pend", 8'h31, 8'h10);
      drive(8'h31, 8'h10, 1'b1, 1'b0); tick(); drive(8'h31, 8'h00, 1'b0, 1'b0);
      read_chk("collide_clear", 8'h31, 8'h00);

      // IRQ held high across reset release
      irq = 8'h02; rst = 1'b1; tick(); tick(); rst = 1'b0;
      tick(); tick(); tick(); tick();
      read_chk("held_high_pend", 8'h31, 8'h00);
      irq = 8'h00; tick(); tick(); tick();

      // asynchronous reset while pending = 06
      drive(8'h30, 8'h06, 1'b1, 1'b0); tick(); drive(8'h00, 8'h00, 1'b0, 1'b0);
      irq = 8'h06; tick(); irq = 8'h00; tick(); tick(); tick();
      read_chk("pre_rst_pend", 8'h31, 8'h06);
      chk("pre_rst_intr", {7'b0, bus.INTERUPT}, 8'h01);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("async_rst_intr", {7'b0, bus.INTERUPT}, 8'h00);
      chk("async_rst_pend", bus.IN_DATA, 8'h00);
      bus.PORT_ID = 8'h30; #0.5;
      chk("async_rst_mask", bus.IN_DATA, 8'h00);
      bus.PORT_ID = 8'h32; #0.5;
      chk("async_rst_id", bus.IN_DATA, 8'hFF);
      tick();
      rst = 1'b0;

      // randomized against the model
      for (int n = 0; n < 400; n++) begin
         logic [7:0] p, d;
         case ($urandom_range(0, 3))
            0: p = 8'h30;
            1: p = 8'h31;
            2: p = 8'h32;
            default: p = 8'h40;
         endcase
         d = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 2) == 0) irq = 8'($urandom_range(0, 255));
         drive(p, d, ($urandom_range(0, 5) == 0), ($urandom_range(0, 4) == 0));
         tick();
         chk("rand_intr", {7'b0, bus.INTERUPT}, {7'b0, m_intr});
         chk("rand_rd", bus.IN_DATA, model_read(bus.PORT_ID));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // watchdog
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule
